// File: rtl/io_input_port.sv
// io_input_port: CPU-read side of the 0x100 I/O window. Synchronizes and
// debounces KEY/SW, latches key-press flags (W1C), masks them onto irq.
// Ports:
//   clk, reset             - clock, async active-high reset
//   addr, memwrite,        - CPU data bus; block selected by addr[8]
//   writedata
//   KEY[3:0], SW[9:0]      - raw asynchronous board inputs (KEY active-low)
//   readdata[31:0]         - combinational register read data
//   irq                    - level request, |(edge & mask)
module io_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        memwrite,
  input  logic [31:0] writedata,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  // KEY idles high (released), SW idles low
  localparam logic [13:0] IN_RST = 14'h000F;

  logic [13:0]   raw;
  logic [13:0]   s1_q;
  logic [13:0]   s2_q;
  logic [13:0]   db_q;
  logic [13:0]   db_d;
  logic [CW-1:0] cnt_q [14];
  logic [CW-1:0] cnt_d [14];
  logic [3:0]    kprev_q;
  logic [3:0]    edge_q;
  logic [3:0]    edge_d;
  logic [3:0]    mask_q;
  logic [3:0]    mask_d;
  logic [3:0]    clr;
  logic [3:0]    fall;
  logic          wr;
  logic          wr_edge;
  logic          wr_mask;
  logic          unused_bits;

  assign raw = {SW, KEY};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= IN_RST;
      s2_q <= IN_RST;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Counter runs while the synced level differs from the accepted one;
  // the level is accepted on the edge after the count reaches the limit,
  // so the counter never exceeds DEBOUNCE_CYCLES. Any agreement clears it.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 14; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Register decode follows read priority KEY > SW > EDGE > MASK
  assign wr      = memwrite & addr[8];
  assign wr_edge = wr & addr[6] & ~addr[5] & ~addr[4];
  assign wr_mask = wr & addr[7] & ~addr[6] & ~addr[5] & ~addr[4];

  assign fall    = kprev_q & ~db_q[3:0];
  assign clr     = wr_edge ? writedata[3:0] : 4'h0;
  // a press landing with its own clear keeps the flag
  assign edge_d  = (edge_q & ~clr) | fall;
  assign mask_d  = wr_mask ? writedata[3:0] : mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q    <= IN_RST;
      kprev_q <= 4'hF;
      edge_q  <= '0;
      mask_q  <= '0;
      for (int i = 0; i < 14; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q    <= db_d;
      kprev_q <= db_q[3:0];
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      for (int i = 0; i < 14; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign irq = |(edge_q & mask_q);

  always_comb begin
    readdata = '0;
    if (addr[8]) begin
      if (addr[4]) begin
        readdata = {28'b0, db_q[3:0]};
      end else if (addr[5]) begin
        readdata = {22'b0, db_q[13:4]};
      end else if (addr[6]) begin
        readdata = {28'b0, edge_q};
      end else if (addr[7]) begin
        readdata = {28'b0, mask_q};
      end
    end
  end

  assign unused_bits = ^{addr[31:9], addr[3:0], writedata[31:4]};

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: scoreboard bench for io_input_port
// (DEBOUNCE_CYCLES = 4, so input latency is 6 edges after sampling).
module tb_io_input_port;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        memwrite;
  logic [31:0] writedata;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] readdata;
  logic        irq;

  io_input_port #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .memwrite (memwrite),
    .writedata(writedata),
    .KEY      (KEY),
    .SW       (SW),
    .readdata (readdata),
    .irq      (irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] a;
    bit          is_irq;
    logic [31:0] exp;
    int          due;
  } item_t;

  item_t sb[$];
  int    n_chk;
  int    n_pass;
  int    cyc;
  int    c0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h want %h (cyc %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push_rd(input string tag, input logic [31:0] a,
                         input logic [31:0] exp, input int dly);
    item_t it;
    it.tag = tag; it.a = a; it.is_irq = 1'b0;
    it.exp = exp; it.due = cyc + dly;
    sb.push_back(it);
  endtask

  task automatic push_irq(input string tag, input logic e, input int dly);
    item_t it;
    it.tag = tag; it.a = '0; it.is_irq = 1'b1;
    it.exp = {31'b0, e}; it.due = cyc + dly;
    sb.push_back(it);
  endtask

  task automatic service();
    int    i;
    item_t it;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        it = sb[i];
        sb.delete(i);
        if (it.is_irq) begin
          #1;
          chk(it.tag, {31'b0, irq}, it.exp);
        end else begin
          addr = it.a;
          #1;
          chk(it.tag, readdata, it.exp);
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    cyc++;
    service();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    tick();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    reset = 1'b1; KEY = 4'hF; SW = '0;
    addr = '0; memwrite = 1'b0; writedata = '0;

    repeat (2) @(posedge clk);
    #1;
    push_rd("rst_key",  32'h110, 32'hF, 0);
    push_rd("rst_sw",   32'h120, 32'h0, 0);
    push_rd("rst_edge", 32'h140, 32'h0, 0);
    push_rd("rst_mask", 32'h180, 32'h0, 0);
    push_irq("rst_irq", 1'b0, 0);
    service();
    @(negedge clk);
    reset = 1'b0;
    tick();

    // clean switch: sampled at cyc+1, visible 6 edges later
    SW = 10'h2A5;
    push_rd("sw_pre1", 32'h120, 32'h0,   1);
    push_rd("sw_pre6", 32'h120, 32'h0,   6);
    push_rd("sw_at7",  32'h120, 32'h2A5, 7);
    push_rd("sw_hold", 32'h120, 32'h2A5, 12);
    repeat (12) tick();

    // bounce: low 3 samples, high 1, then low; last change sampled at c0+5
    c0 = cyc;
    KEY = 4'hE;
    push_rd("bnc_key5",  32'h110, 32'hF, 5);
    push_rd("bnc_key10", 32'h110, 32'hF, 10);
    push_rd("bnc_key11", 32'h110, 32'hE, 11);
    push_rd("bnc_edge11", 32'h140, 32'h0, 11);
    push_rd("bnc_edge12", 32'h140, 32'h1, 12);
    push_irq("bnc_irq12", 1'b0, 12);
    push_rd("bnc_edge14", 32'h140, 32'h1, 14);
    repeat (3) tick();
    KEY = 4'hF;
    tick();
    KEY = 4'hE;
    while (cyc < c0 + 14) tick();

    // interrupt and clear
    wr(32'h180, 32'h1);
    push_rd("irq_mask", 32'h180, 32'h1, 0);
    push_irq("irq_on", 1'b1, 0);
    service();
    wr(32'h140, 32'h0);
    push_rd("w0_edge", 32'h140, 32'h1, 0);
    push_irq("w0_irq", 1'b1, 0);
    service();
    wr(32'h140, 32'h1);
    push_rd("w1c_edge", 32'h140, 32'h0, 0);
    push_irq("w1c_irq", 1'b0, 0);
    service();

    // release must not set a flag
    KEY = 4'hF;
    push_rd("rel_key",  32'h110, 32'hF, 10);
    push_rd("rel_edge", 32'h140, 32'h0, 10);
    repeat (10) tick();

    // second press raises irq one edge after key_db falls
    KEY = 4'hE;
    push_irq("pr2_irq7", 1'b0, 7);
    push_irq("pr2_irq8", 1'b1, 8);
    push_rd("pr2_edge8", 32'h140, 32'h1, 8);
    repeat (9) tick();
    wr(32'h140, 32'h1);
    push_rd("pr2_clr", 32'h140, 32'h0, 0);
    service();

    // collision: W1C of bit1 lands on the edge that sets edge[1]
    KEY = 4'hC;
    c0 = cyc;
    push_rd("col_key7",  32'h110, 32'hC, 7);
    push_rd("col_edge7", 32'h140, 32'h0, 7);
    repeat (7) tick();
    wr(32'h140, 32'h2);
    push_rd("col_edge8", 32'h140, 32'h2, 0);
    push_irq("col_irq8", 1'b0, 0);
    service();
    push_rd("col_edge9", 32'h140, 32'h2, 1);
    tick();

    // decode
    wr(32'h080, 32'hFF);
    wr(32'h110, 32'hFF);
    push_rd("dec_mask", 32'h180, 32'h1, 0);
    push_rd("dec_edge", 32'h140, 32'h2, 0);
    push_rd("dec_060",  32'h060, 32'h0, 0);
    service();
    push_rd("dec_130", 32'h130, 32'hC, 1);
    push_rd("dec_1c0", 32'h1C0, 32'h2, 1);
    push_rd("dec_100", 32'h100, 32'h0, 1);
    tick();

    repeat (2) tick();
    while (sb.size() > 0) begin
      n_chk++;
      $display("FAIL %s: got unchecked want checked", sb[0].tag);
      void'(sb.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
